// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: sequences one convolution layer on the `top` datapath.
// For each channel it streams weight words and then ifmap words from a host
// valid/ready stream into the spads, routes until `top` reports done, then
// moves on to the next channel. All outputs are registered.
// Optional feature macro: LAYER_SEQ_WDOG_EN (ROUTE watchdog, WDOG_CYCLES limit).
module layer_seq_ctrl #(
  parameter int unsigned SPAD_DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned CYC_WIDTH       = 32
`ifdef LAYER_SEQ_WDOG_EN
  , parameter int unsigned WDOG_CYCLES   = 65535
`endif
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [ADDR_WIDTH-1:0]      i_w_words,
  input  logic [ADDR_WIDTH-1:0]      i_i_words,
  input  logic [ADDR_WIDTH-1:0]      i_c_size,
  input  logic [SPAD_DATA_WIDTH-1:0] i_s_data,
  input  logic                       i_s_valid,
  output logic                       o_s_ready,
  output logic [SPAD_DATA_WIDTH-1:0] o_data_in,
  output logic [ADDR_WIDTH-1:0]      o_write_addr,
  output logic                       o_spad_select,
  output logic                       o_write_en,
  output logic                       o_reg_clear,
  output logic                       o_route_en,
  output logic [ADDR_WIDTH-1:0]      o_i_addr_end,
  output logic [ADDR_WIDTH-1:0]      o_i_c,
  input  logic                       i_done,
  output logic                       o_busy,
  output logic                       o_layer_done,
  output logic                       o_err,
  output logic [CYC_WIDTH-1:0]       o_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_W, S_LOAD_I, S_GAP, S_ROUTE, S_NEXT, S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      w_words_q, w_words_d;
  logic [ADDR_WIDTH-1:0]      i_words_q, i_words_d;
  logic [ADDR_WIDTH-1:0]      c_size_q, c_size_d;
  logic [ADDR_WIDTH-1:0]      beat_q, beat_d;
  logic                       gap_q, gap_d;
  logic [ADDR_WIDTH-1:0]      ic_q, ic_d;
  logic [ADDR_WIDTH-1:0]      addr_end_q, addr_end_d;
  logic [CYC_WIDTH-1:0]       cycles_q, cycles_d;
  logic                       err_q, err_d;
  logic                       ready_q, ready_d;
  logic                       wr_en_q, wr_en_d;
  logic [SPAD_DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic                       sel_q, sel_d;
  logic                       clear_q, clear_d;
  logic                       route_q, route_d;
  logic                       busy_q, busy_d;
  logic                       ldone_q, ldone_d;
  logic                       accept;

`ifdef LAYER_SEQ_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout;
`endif

  assign accept = i_s_valid & ready_q;

  // State and output registers; reset aborts any layer in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      w_words_q  <= '0;
      i_words_q  <= '0;
      c_size_q   <= '0;
      beat_q     <= '0;
      gap_q      <= 1'b0;
      ic_q       <= '0;
      addr_end_q <= '0;
      cycles_q   <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      sel_q      <= 1'b0;
      clear_q    <= 1'b0;
      route_q    <= 1'b0;
      busy_q     <= 1'b0;
      ldone_q    <= 1'b0;
`ifdef LAYER_SEQ_WDOG_EN
      wdog_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      w_words_q  <= w_words_d;
      i_words_q  <= i_words_d;
      c_size_q   <= c_size_d;
      beat_q     <= beat_d;
      gap_q      <= gap_d;
      ic_q       <= ic_d;
      addr_end_q <= addr_end_d;
      cycles_q   <= cycles_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      wr_en_q    <= wr_en_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      clear_q    <= clear_d;
      route_q    <= route_d;
      busy_q     <= busy_d;
      ldone_q    <= ldone_d;
`ifdef LAYER_SEQ_WDOG_EN
      wdog_q     <= wdog_d;
`endif
    end
  end

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    w_words_d  = w_words_q;
    i_words_d  = i_words_q;
    c_size_d   = c_size_q;
    beat_d     = beat_q;
    gap_d      = gap_q;
    ic_d       = ic_q;
    addr_end_d = addr_end_q;
    cycles_d   = cycles_q;
    err_d      = err_q;
    wr_en_d    = 1'b0;
    data_d     = data_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
`ifdef LAYER_SEQ_WDOG_EN
    wdog_d     = wdog_q;
    timeout    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          w_words_d = i_w_words;
          i_words_d = i_i_words;
          c_size_d  = i_c_size;
          if (i_i_words == '0 || i_c_size == '0) begin
            err_d = 1'b1;
          end else begin
            err_d    = 1'b0;
            cycles_d = '0;
            ic_d     = '0;
            state_d  = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        beat_d  = '0;
        state_d = (w_words_q == '0) ? S_LOAD_I : S_LOAD_W;
      end
      S_LOAD_W: begin
        // The cycle carrying the final write is also the last LOAD_W cycle.
        if (beat_q == w_words_q) begin
          beat_d  = '0;
          state_d = S_LOAD_I;
        end else if (accept) begin
          wr_en_d = 1'b1;
          data_d  = i_s_data;
          addr_d  = beat_q;
          sel_d   = 1'b0;
          beat_d  = beat_q + ADDR_WIDTH'(1);
        end
      end
      S_LOAD_I: begin
        if (beat_q == i_words_q) begin
          gap_d   = 1'b0;
          state_d = S_GAP;
        end else if (accept) begin
          wr_en_d = 1'b1;
          data_d  = i_s_data;
          addr_d  = beat_q;
          sel_d   = 1'b1;
          beat_d  = beat_q + ADDR_WIDTH'(1);
        end
      end
      S_GAP: begin
        if (gap_q) begin
          state_d = S_ROUTE;
`ifdef LAYER_SEQ_WDOG_EN
          wdog_d  = '0;
`endif
        end else begin
          gap_d = 1'b1;
        end
      end
      S_ROUTE: begin
        if (cycles_q != '1) cycles_d = cycles_q + CYC_WIDTH'(1);
        if (i_done) begin
          state_d = S_NEXT;
        end
`ifdef LAYER_SEQ_WDOG_EN
        else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          timeout = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end
      S_NEXT: begin
        if (ic_q == c_size_q - ADDR_WIDTH'(1)) begin
          state_d = S_DONE;
        end else begin
          ic_d    = ic_q + ADDR_WIDTH'(1);
          beat_d  = '0;
          state_d = (w_words_q == '0) ? S_LOAD_I : S_LOAD_W;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Last input address is captured on every entry into LOAD_I.
    if (state_d == S_LOAD_I && state_q != S_LOAD_I) begin
      addr_end_d = i_words_q - ADDR_WIDTH'(1);
    end

    ready_d = ((state_d == S_LOAD_W) && (beat_d < w_words_q)) ||
              ((state_d == S_LOAD_I) && (beat_d < i_words_q));
`ifdef LAYER_SEQ_WDOG_EN
    clear_d = (state_d == S_CLEAR) || timeout;
`else
    clear_d = (state_d == S_CLEAR);
`endif
    route_d = (state_d == S_ROUTE);
    busy_d  = (state_d != S_IDLE);
    ldone_d = (state_d == S_DONE);
  end

  assign o_s_ready     = ready_q;
  assign o_data_in     = data_q;
  assign o_write_addr  = addr_q;
  assign o_spad_select = sel_q;
  assign o_write_en    = wr_en_q;
  assign o_reg_clear   = clear_q;
  assign o_route_en    = route_q;
  assign o_i_addr_end  = addr_end_q;
  assign o_i_c         = ic_q;
  assign o_busy        = busy_q;
  assign o_layer_done  = ldone_q;
  assign o_err         = err_q;
  assign o_cycles      = cycles_q;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed testbench for layer_seq_ctrl.
// Build with LAYER_SEQ_WDOG_EN defined to also exercise the watchdog (limit 20).
module tb_layer_seq_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [AW-1:0] i_w_words, i_i_words, i_c_size;
  logic [DW-1:0] i_s_data;
  logic          i_s_valid;
  logic          o_s_ready;
  logic [DW-1:0] o_data_in;
  logic [AW-1:0] o_write_addr;
  logic          o_spad_select, o_write_en, o_reg_clear, o_route_en;
  logic [AW-1:0] o_i_addr_end, o_i_c;
  logic          i_done, o_busy, o_layer_done, o_err;
  logic [CW-1:0] o_cycles;

  always #5 clk = ~clk;

  layer_seq_ctrl #(
    .SPAD_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CYC_WIDTH(CW)
`ifdef LAYER_SEQ_WDOG_EN
    , .WDOG_CYCLES(20)
`endif
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_w_words(i_w_words), .i_i_words(i_i_words), .i_c_size(i_c_size),
    .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .o_data_in(o_data_in), .o_write_addr(o_write_addr),
    .o_spad_select(o_spad_select), .o_write_en(o_write_en),
    .o_reg_clear(o_reg_clear), .o_route_en(o_route_en),
    .o_i_addr_end(o_i_addr_end), .o_i_c(o_i_c), .i_done(i_done),
    .o_busy(o_busy), .o_layer_done(o_layer_done), .o_err(o_err),
    .o_cycles(o_cycles)
  );

  int checks   = 0;
  int failures = 0;
  int clr_cnt, done_cnt;
  logic [DW-1:0] stream [$];
  logic          wq_sel [$];
  logic [AW-1:0] wq_addr [$];
  logic [AW-1:0] wq_ic [$];
  logic [DW-1:0] wq_data [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int ch, input int sel, input int idx);
    return {16'hD0D0, 8'(ch), 8'(sel), 16'h5A5A, 16'(idx)};
  endfunction

  function automatic logic [127:0] all_outs();
    return 128'({o_s_ready, o_data_in, o_write_addr, o_spad_select, o_write_en,
                 o_reg_clear, o_route_en, o_i_addr_end, o_i_c, o_busy,
                 o_layer_done, o_err, o_cycles});
  endfunction

  task automatic prep(input int w, input int iw, input int c);
    stream.delete();
    wq_sel.delete(); wq_addr.delete(); wq_ic.delete(); wq_data.delete();
    clr_cnt = 0; done_cnt = 0;
    for (int ch = 0; ch < c; ch++) begin
      for (int k = 0; k < w; k++)  stream.push_back(word_of(ch, 0, k));
      for (int k = 0; k < iw; k++) stream.push_back(word_of(ch, 1, k));
    end
  endtask

  task automatic start(input int w, input int iw, input int c);
    @(negedge clk);
    i_w_words = AW'(w); i_i_words = AW'(iw); i_c_size = AW'(c);
    i_start = 1'b1;
  endtask

  // Per-cycle driver/monitor: feeds the stream, records writes, answers route with i_done.
  task automatic run_layer(input bit toggle, input int done_after, input int rst_at,
                           input int budget, output bit finished, output int route_max);
    int route_cnt, phase, sidx;
    bit drove_valid, ready_seen, aborted;
    route_cnt = 0; phase = 0; sidx = 0; drove_valid = 0; ready_seen = 0;
    aborted = 0; finished = 0; route_max = 0;
    for (int cyc = 0; cyc < budget && !finished && !aborted; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (drove_valid && ready_seen) sidx++;
      if (o_write_en) begin
        wq_sel.push_back(o_spad_select); wq_addr.push_back(o_write_addr);
        wq_ic.push_back(o_i_c); wq_data.push_back(o_data_in);
      end
      if (o_reg_clear) clr_cnt++;
      if (o_layer_done) begin done_cnt++; finished = 1; end
      if (o_route_en) route_cnt++; else route_cnt = 0;
      if (route_cnt > route_max) route_max = route_cnt;
      i_done = o_route_en && (route_cnt == done_after);
      if (rst_at >= 0 && o_write_en && o_spad_select && int'(o_write_addr) == rst_at) begin
        #1 i_rst = 1'b1;
        #1 chk("outputs_zero_in_reset", all_outs(), 128'(0));
        @(negedge clk);
        i_rst = 1'b0;
        aborted = 1;
      end else begin
        drove_valid = (sidx < stream.size()) && (!toggle || phase[0]);
        phase++;
        i_s_valid = drove_valid;
        i_s_data  = drove_valid ? stream[sidx] : '0;
        ready_seen = o_s_ready;
      end
    end
    i_s_valid = 1'b0;
    i_done = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int w, input int iw, input int c);
    int k = 0;
    chk({tag, "_write_count"}, 128'(wq_sel.size()), 128'(c * (w + iw)));
    for (int ch = 0; ch < c; ch++) begin
      for (int s = 0; s < 2; s++) begin
        for (int a = 0; a < ((s == 0) ? w : iw); a++) begin
          if (k < wq_sel.size()) begin
            chk({tag, "_write"},
                128'({wq_sel[k], wq_addr[k], wq_ic[k], wq_data[k]}),
                128'({1'(s), AW'(a), AW'(ch), word_of(ch, s, a)}));
          end
          k++;
        end
      end
    end
  endtask

  bit fin;
  int rmax;

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_w_words = '0; i_i_words = '0; i_c_size = '0;
    i_s_data = '0; i_s_valid = 1'b0; i_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 128'(0));
    i_rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 128'(o_busy), 128'(0));

    // i_done outside ROUTE has no effect
    i_done = 1'b1;
    @(negedge clk);
    i_done = 1'b0;
    @(negedge clk);
    chk("idle_done_ignored", 128'({o_busy, o_route_en, o_layer_done}), 128'(0));

    // single channel, 9 weight + 100 ifmap words, done after 50 route cycles
    prep(9, 100, 1);
    start(9, 100, 1);
    run_layer(0, 50, -1, 800, fin, rmax);
    chk("t1_finished", 128'(fin), 128'(1));
    check_writes("t1", 9, 100, 1);
    chk("t1_addr_end", 128'(o_i_addr_end), 128'(99));
    chk("t1_cycles", 128'(o_cycles), 128'(50));
    chk("t1_route_len", 128'(rmax), 128'(50));
    chk("t1_clear_pulses", 128'(clr_cnt), 128'(1));
    chk("t1_done_pulses", 128'(done_cnt), 128'(1));
    @(negedge clk);
    chk("t1_idle_after", 128'({o_busy, o_layer_done, o_err}), 128'(0));

    // two channels: loads repeat, one clear pulse, cumulative cycles
    prep(2, 3, 2);
    start(2, 3, 2);
    run_layer(0, 5, -1, 300, fin, rmax);
    chk("t2_finished", 128'(fin), 128'(1));
    check_writes("t2", 2, 3, 2);
    chk("t2_clear_pulses", 128'(clr_cnt), 128'(1));
    chk("t2_cycles", 128'(o_cycles), 128'(10));
    chk("t2_channel_idx", 128'(o_i_c), 128'(1));
    chk("t2_addr_end", 128'(o_i_addr_end), 128'(2));

    // stream valid only every other cycle
    prep(3, 4, 1);
    start(3, 4, 1);
    run_layer(1, 3, -1, 300, fin, rmax);
    chk("t3_finished", 128'(fin), 128'(1));
    check_writes("t3", 3, 4, 1);
    chk("t3_cycles", 128'(o_cycles), 128'(3));
    chk("t3_addr_end", 128'(o_i_addr_end), 128'(3));

    // invalid parameters: channel count 0, then ifmap words 0
    start(3, 4, 0);
    @(negedge clk);
    i_start = 1'b0;
    chk("t4_err_c0", 128'({o_err, o_busy}), 128'(2'b10));
    repeat (3) @(negedge clk);
    chk("t4_still_idle", 128'({o_err, o_busy, o_write_en, o_s_ready}), 128'(4'b1000));
    start(2, 0, 1);
    @(negedge clk);
    i_start = 1'b0;
    chk("t4_err_i0", 128'({o_err, o_busy}), 128'(2'b10));
    // valid start without weights clears the error
    prep(0, 5, 1);
    start(0, 5, 1);
    run_layer(0, 2, -1, 200, fin, rmax);
    chk("t4_finished", 128'(fin), 128'(1));
    chk("t4_err_cleared", 128'(o_err), 128'(0));
    check_writes("t4", 0, 5, 1);

    // reset during ifmap beat 40, then a clean restart
    prep(4, 60, 1);
    start(4, 60, 1);
    run_layer(0, 10, 40, 400, fin, rmax);
    chk("t5_aborted", 128'(fin), 128'(0));
    i_s_valid = 1'b1;
    i_s_data  = 64'hDEAD_BEEF_0000_0000;
    repeat (3) @(negedge clk);
    chk("t5_no_writes_after_reset", 128'({o_write_en, o_busy, o_s_ready}), 128'(0));
    i_s_valid = 1'b0;
    prep(4, 60, 1);
    start(4, 60, 1);
    run_layer(0, 10, -1, 400, fin, rmax);
    chk("t5_restart_finished", 128'(fin), 128'(1));
    check_writes("t5", 4, 60, 1);
    chk("t5_cycles", 128'(o_cycles), 128'(10));

`ifdef LAYER_SEQ_WDOG_EN
    // watchdog: i_done never arrives
    prep(1, 1, 1);
    start(1, 1, 1);
    run_layer(0, 100000, -1, 120, fin, rmax);
    chk("wd_no_done", 128'({fin, 8'(done_cnt)}), 128'(0));
    chk("wd_route_len", 128'(rmax), 128'(20));
    chk("wd_state", 128'({o_err, o_busy, o_route_en}), 128'(3'b100));
    chk("wd_clear_pulses", 128'(clr_cnt), 128'(2));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_seq_ctrl.md
Name: layer_seq_ctrl

Overview:
- Sequences one convolution layer on the accelerator `top` datapath, channel by channel.
- Per channel: streams weight words into the weight spad and ifmap words into the input spad from a host valid/ready stream, then asserts route enable until the datapath reports done.
- Advances the channel index and repeats until all channels are processed; reports completion and route cycle count.
- Sits between the host/DMA interface and `top`, replacing testbench-driven loading.

Parameters:
- SPAD_DATA_WIDTH, 64, spad word width (matches `SPAD_DATA_WIDTH`).
- ADDR_WIDTH, 8, spad address and size-field width (matches `ADDR_WIDTH`).
- CYC_WIDTH, 32, route cycle counter width.
- WDOG_CYCLES, 65535, watchdog limit in ROUTE (used only with the optional feature).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_start  in  1  one-cycle layer start request.
- i_w_words  in  ADDR_WIDTH  weight words per channel.
- i_i_words  in  ADDR_WIDTH  ifmap words per channel.
- i_c_size  in  ADDR_WIDTH  channel count.
- i_s_data  in  SPAD_DATA_WIDTH  host stream data.
- i_s_valid  in  1  host stream valid.
- o_s_ready  out  1  stream ready.
- o_data_in  out  SPAD_DATA_WIDTH  spad write data to `top`.
- o_write_addr  out  ADDR_WIDTH  spad write address.
- o_spad_select  out  1  0 = weight spad, 1 = input spad.
- o_write_en  out  1  spad write strobe.
- o_reg_clear  out  1  accumulator clear pulse.
- o_route_en  out  1  route enable to `top`.
- o_i_addr_end  out  ADDR_WIDTH  input spad last address.
- o_i_c  out  ADDR_WIDTH  current channel index.
- i_done  in  1  `o_done` from `top`.
- o_busy  out  1  layer in progress.
- o_layer_done  out  1  one-cycle completion pulse.
- o_err  out  1  sticky error flag; cleared by the next accepted start.
- o_cycles  out  CYC_WIDTH  cumulative ROUTE cycles for the current layer.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; counters 0.
  - Reset mid-operation aborts immediately; no further writes are issued.
- Start handling:
  - i_start is accepted only in IDLE.
  - At acceptance, i_w_words, i_i_words and i_c_size are latched.
  - If latched i_i_words==0 or i_c_size==0: set o_err, stay IDLE.
  - Otherwise: clear o_err and o_cycles, set o_i_c=0, go to CLEAR.
  - i_start while busy is ignored.
- States: IDLE, CLEAR, LOAD_W, LOAD_I, GAP, ROUTE, NEXT, DONE.
- CLEAR:
  - o_reg_clear=1 for exactly one cycle, at layer start only, never between channels.
  - Next state: LOAD_W, or LOAD_I if w_words==0.
- LOAD_W / LOAD_I:
  - o_s_ready=1 while the beat count is below the word count.
  - A beat is accepted when i_s_valid & o_s_ready.
  - The cycle after an accepted beat: o_write_en=1, o_data_in=beat data, o_write_addr=beat index (starting at 0), o_spad_select=0 in LOAD_W or 1 in LOAD_I.
  - i_s_valid gaps are tolerated; o_write_en stays 0 in gap cycles.
  - After the last beat is accepted, o_s_ready drops the same cycle.
  - State advances after the final write cycle: LOAD_W -> LOAD_I, LOAD_I -> GAP.
  - The address counter resets to 0 on entering each load state.
  - o_i_addr_end = i_words-1, registered on entering LOAD_I and held until the next start.
- GAP: 2 idle cycles to let spad writes settle, then ROUTE.
- ROUTE:
  - o_route_en=1; o_cycles increments every cycle in ROUTE.
  - On i_done=1: o_route_en drops the next cycle; go to NEXT.
  - i_done in any other state is ignored.
- NEXT:
  - If o_i_c == c_size-1, go to DONE.
  - Otherwise increment o_i_c and go to LOAD_W (or LOAD_I if w_words==0).
- DONE: o_layer_done=1 for one cycle, then IDLE.
- o_busy=1 in every state except IDLE.
- Counters wrap at 2^width; o_cycles saturates at its maximum value instead of wrapping.

Optional Feature:
- Macro: LAYER_SEQ_WDOG_EN.
- Defined:
  - A counter runs in ROUTE and resets on each ROUTE entry.
  - If it reaches WDOG_CYCLES without i_done: set o_err, drop o_route_en, pulse o_reg_clear once, return to IDLE without pulsing o_layer_done.
- Undefined: no watchdog; ROUTE waits indefinitely; o_err is set only by invalid start parameters.

Test Plan:
- w_words=9, i_words=100, c_size=1, continuous valid, i_done 50 cycles after route_en -> 9 writes at addresses 0..8 with select=0, then 100 writes at 0..99 with select=1; o_i_addr_end=99; o_cycles=50; one o_layer_done pulse.
- c_size=2 -> o_i_c reads 0 then 1; load sequence repeats for each channel; o_reg_clear pulses exactly once.
- i_s_valid toggling every other cycle -> identical address/data sequence with write gaps; no duplicated or skipped addresses.
- i_start with i_c_size=0 -> o_err=1, o_busy stays 0, no writes; a following valid start clears o_err.
- i_rst asserted during LOAD_I beat 40 -> all outputs 0 that cycle; restart completes normally.
- LAYER_SEQ_WDOG_EN with WDOG_CYCLES=20 and i_done never asserted -> o_route_en drops after 20 cycles, o_err=1, no o_layer_done pulse.
